// File: rtl/lambda_line_editor.sv
// lambda_line_editor
// Line editor for the lambda-calculus console. Collects printable key codes
// into a line buffer and echoes each one. On Enter it walks the stored line
// at the clk_io pace, then reports the line class and the syntax verdict on
// the cmd status byte.
//
// Handshake: there is no backpressure. A nonzero ch_input on a clock is one
// key event and is consumed on that clock or dropped (SCAN and DONE drop all
// keys). ch_append is a 1-cycle strobe, nonzero exactly on the cycle after a
// key was stored. cmd[1] and cmd[6] are 1-cycle pulses. cmd[0] is high from
// the cycle after Enter through the DONE cycle.
module lambda_line_editor #(
  parameter int         MAX_LEN    = 64,
  parameter logic [7:0] CODE_BS    = 8'd65,
  parameter logic [7:0] CODE_ENTER = 8'd66
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       clk_io,
  input  logic [7:0] ch_input,
  output logic [5:0] ch_append,
  output logic [7:0] cmd
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] FULL_LEN = LW'(MAX_LEN);

  // Character codes that steer the scan
  localparam logic [5:0] C_DOLLAR = 6'd53;
  localparam logic [5:0] C_LPAREN = 6'd54;
  localparam logic [5:0] C_RPAREN = 6'd55;
  localparam logic [5:0] C_EQUAL  = 6'd56;
  localparam logic [5:0] C_SPACE  = 6'd59;

  // Editor states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Control and status registers
  logic [1:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic          io_prev_q;
  logic [5:0]    echo_q, echo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          def_q, def_d;
  logic          expr_q, expr_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          erase_q, erase_d;

  // Scan trackers
  logic signed [6:0] depth_q, depth_d;
  logic              neg_q, neg_d;        // depth dipped below zero
  logic              dollar_q, dollar_d;  // first character is '$'
  logic [1:0]        eq_cnt_q, eq_cnt_d;  // saturating '=' count
  logic              gap_ok_q, gap_ok_d;  // first '=' sits at index >= 2
  logic              after_ok_q, after_ok_d; // non-space seen after an '='
  logic              nonspace_q, nonspace_d; // line has a non-space char

  // Line storage
  logic [5:0] buf_q [MAX_LEN];

  logic       key_printable;
  logic       key_bs;
  logic       key_enter;
  logic       io_edge;
  logic       scan_end;
  logic [5:0] scan_ch;
  logic       wr_en;
  logic       depth_bad;
  logic       def_err;
  logic       expr_err;

  assign key_printable = (ch_input != 8'd0) && (ch_input[7:6] == 2'b00);
  assign key_bs        = (ch_input == CODE_BS);
  assign key_enter     = (ch_input == CODE_ENTER);
  assign io_edge       = clk_io & ~io_prev_q;
  assign scan_end      = (idx_q == len_q);
  assign scan_ch       = buf_q[idx_q[AW-1:0]];
  assign wr_en         = (state_q == ST_IDLE) && key_printable &&
                         (len_q < FULL_LEN);

  // Verdict terms evaluated on the finished trackers
  assign depth_bad = neg_q || (depth_q != 7'sd0);
  assign def_err   = (eq_cnt_q != 2'd1) || !gap_ok_q || !after_ok_q;
  assign expr_err  = (eq_cnt_q != 2'd0);

  // Next-state logic for the editor FSM, status flags and scan trackers
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    echo_d     = 6'd0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    def_d      = def_q;
    expr_d     = expr_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    erase_d    = 1'b0;
    depth_d    = depth_q;
    neg_d      = neg_q;
    dollar_d   = dollar_q;
    eq_cnt_d   = eq_cnt_q;
    gap_ok_d   = gap_ok_q;
    after_ok_d = after_ok_q;
    nonspace_d = nonspace_q;

    case (state_q)
      ST_IDLE: begin
        if (key_enter) begin
          // Enter takes priority over everything else on this clock
          state_d    = ST_SCAN;
          busy_d     = 1'b1;
          def_d      = 1'b0;
          expr_d     = 1'b0;
          err_d      = 1'b0;
          ovf_d      = 1'b0;
          idx_d      = '0;
          depth_d    = 7'sd0;
          neg_d      = 1'b0;
          dollar_d   = 1'b0;
          eq_cnt_d   = 2'd0;
          gap_ok_d   = 1'b0;
          after_ok_d = 1'b0;
          nonspace_d = 1'b0;
        end else if (key_bs) begin
          if (len_q != '0) begin
            len_d   = len_q - LW'(1);
            erase_d = 1'b1;
          end
        end else if (key_printable) begin
          if (len_q < FULL_LEN) begin
            len_d  = len_q + LW'(1);
            echo_d = ch_input[5:0];
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      ST_SCAN: begin
        if (io_edge) begin
          if (scan_end) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (!nonspace_q) begin
              def_d  = 1'b0;
              expr_d = 1'b0;
              err_d  = depth_bad;
            end else if (dollar_q) begin
              def_d  = 1'b1;
              expr_d = 1'b0;
              err_d  = def_err || depth_bad;
            end else begin
              def_d  = 1'b0;
              expr_d = 1'b1;
              err_d  = expr_err || depth_bad;
            end
          end else begin
            idx_d = idx_q + LW'(1);
            if ((idx_q == '0) && (scan_ch == C_DOLLAR)) dollar_d = 1'b1;
            if (scan_ch != C_SPACE) nonspace_d = 1'b1;
            if ((eq_cnt_q != 2'd0) && (scan_ch != C_SPACE)) after_ok_d = 1'b1;
            case (scan_ch)
              C_LPAREN: depth_d = depth_q + 7'sd1;
              C_RPAREN: begin
                if (depth_q == 7'sd0) neg_d = 1'b1;
                depth_d = depth_q - 7'sd1;
              end
              C_EQUAL: begin
                if ((eq_cnt_q == 2'd0) && (idx_q >= LW'(2))) gap_ok_d = 1'b1;
                if (eq_cnt_q != 2'd3) eq_cnt_d = eq_cnt_q + 2'd1;
              end
              default: ;
            endcase
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        len_d   = '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Register update with synchronous reset
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      io_prev_q  <= 1'b0;
      echo_q     <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      def_q      <= 1'b0;
      expr_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      erase_q    <= 1'b0;
      depth_q    <= 7'sd0;
      neg_q      <= 1'b0;
      dollar_q   <= 1'b0;
      eq_cnt_q   <= 2'd0;
      gap_ok_q   <= 1'b0;
      after_ok_q <= 1'b0;
      nonspace_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      io_prev_q  <= clk_io;
      echo_q     <= echo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      def_q      <= def_d;
      expr_q     <= expr_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      erase_q    <= erase_d;
      depth_q    <= depth_d;
      neg_q      <= neg_d;
      dollar_q   <= dollar_d;
      eq_cnt_q   <= eq_cnt_d;
      gap_ok_q   <= gap_ok_d;
      after_ok_q <= after_ok_d;
      nonspace_q <= nonspace_d;
    end
  end

  // Line buffer write; contents need no reset since length gates every read
  always_ff @(posedge clk_25mhz) begin
    if (wr_en) buf_q[len_q[AW-1:0]] <= ch_input[5:0];
  end

  assign ch_append = echo_q;
  assign cmd       = {1'b0, erase_q, ovf_q, err_q, expr_q, def_q, done_q, busy_q};

endmodule

// File: tb/tb_lambda_line_editor.sv
// Directed bench for lambda_line_editor: typed lines with hand-computed
// echoes and status bytes, overflow, backspace, and reset during a scan.
module tb_lambda_line_editor;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_io;
  logic [7:0] ch_input;
  logic [5:0] ch_append;
  logic [7:0] cmd;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] got_q[$];
  logic [5:0] exp_q[$];
  int         key_q[$];
  int         erase_cnt = 0;
  int         io_div = 0;

  lambda_line_editor dut (
    .clk_25mhz (clk),
    .reset     (reset),
    .clk_io    (clk_io),
    .ch_input  (ch_input),
    .ch_append (ch_append),
    .cmd       (cmd)
  );

  // Clock and watchdog
  always #20 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: sample outputs 1 ns after the edge, pace clk_io, log echoes
  task automatic tick();
    @(posedge clk);
    #1;
    io_div++;
    if (io_div == 2) begin
      io_div = 0;
      clk_io = ~clk_io;
    end
    if (ch_append != 6'd0) got_q.push_back(ch_append);
    if (cmd[6]) erase_cnt++;
  endtask

  // Drive key_q on consecutive clocks
  task automatic type_keys();
    foreach (key_q[i]) begin
      ch_input = 8'(key_q[i]);
      tick();
    end
    ch_input = 8'd0;
  endtask

  // Expected echoes: printable codes in order
  task automatic build_exp();
    exp_q.delete();
    foreach (key_q[i])
      if (key_q[i] >= 1 && key_q[i] <= 63) exp_q.push_back(6'(key_q[i]));
  endtask

  // Run clocks until the done pulse or the cycle budget runs out
  task automatic wait_done(input bit busy_keys, output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < 400) begin
      if (busy_keys) ch_input = 8'($urandom_range(1, 63));
      tick();
      cycles++;
      if (cmd[1]) found = 1'b1;
    end
    ch_input = 8'd0;
  endtask

  task automatic test_reset();
    bit found;
    int cycles;
    reset = 1'b1; ch_input = 8'd0; clk_io = 1'b0;
    tick(); tick();
    n_cmp++; if (cmd !== 8'h00) begin n_err++; $display("FAIL reset_cmd: got %h expected 00", cmd); end
    n_cmp++; if (ch_append !== 6'd0) begin n_err++; $display("FAIL reset_echo: got %0d expected 0", ch_append); end
    reset = 1'b0;
    got_q.delete();
    ch_input = 8'd59; tick();
    n_cmp++; if (ch_append !== 6'd59) begin n_err++; $display("FAIL space_echo: got %0d expected 59", ch_append); end
    ch_input = 8'd66; tick();
    n_cmp++; if (ch_append !== 6'd0) begin n_err++; $display("FAIL echo_one_cycle: got %0d expected 0", ch_append); end
    n_cmp++; if (cmd !== 8'h01) begin n_err++; $display("FAIL enter_busy: got %h expected 01", cmd); end
    ch_input = 8'd0;
    wait_done(1'b0, found, cycles);
    n_cmp++; if (!found || cycles > 12) begin n_err++; $display("FAIL space_done: found %0d after %0d cycles, expected within 12", found, cycles); end
    tick();
    n_cmp++; if (cmd !== 8'h00) begin n_err++; $display("FAIL space_result: got %h expected 00", cmd); end
  endtask

  task automatic test_definition();
    bit found;
    int cycles;
    key_q = '{53, 9, 4, 59, 56, 58, 24, 60, 24, 66};
    build_exp();
    got_q.delete();
    type_keys();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL def_echo_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL def_echo[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    wait_done(1'b0, found, cycles);
    n_cmp++; if (!found) begin n_err++; $display("FAIL def_done: no done pulse within %0d cycles", cycles); end
    tick();
    n_cmp++; if (cmd !== 8'h04) begin n_err++; $display("FAIL def_result: got %h expected 04", cmd); end
  endtask

  task automatic test_back_to_back();
    bit found;
    int cycles;
    key_q = '{54, 58, 24, 24, 60, 24, 24, 55, 59, 1, 66};
    build_exp();
    got_q.delete();
    type_keys();
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_echo_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_echo[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    wait_done(1'b0, found, cycles);
    n_cmp++; if (!found) begin n_err++; $display("FAIL b2b_done: no done pulse within %0d cycles", cycles); end
    tick();
    n_cmp++; if (cmd !== 8'h08) begin n_err++; $display("FAIL b2b_result: got %h expected 08", cmd); end
  endtask

  task automatic test_syntax();
    bit         found;
    int         cycles;
    logic [7:0] exp_cmd;
    for (int t = 0; t < 6; t++) begin
      case (t)
        0: begin key_q = '{54, 1, 66};         exp_cmd = 8'h18; end // "(a"
        1: begin key_q = '{1, 56, 2, 66};      exp_cmd = 8'h18; end // "a=b"
        2: begin key_q = '{53, 56, 24, 66};    exp_cmd = 8'h14; end // "$=x"
        3: begin key_q = '{53, 1, 56, 59, 66}; exp_cmd = 8'h14; end // "$a= "
        4: begin key_q = '{55, 54, 66};        exp_cmd = 8'h18; end // ")("
        default: begin key_q = '{59, 59, 66}; exp_cmd = 8'h00; end // "  "
      endcase
      type_keys();
      wait_done(1'b0, found, cycles);
      n_cmp++; if (!found) begin n_err++; $display("FAIL syntax_done[%0d]: no done pulse within %0d cycles", t, cycles); end
      tick();
      n_cmp++; if (cmd !== exp_cmd) begin n_err++; $display("FAIL syntax_result[%0d]: got %h expected %h", t, cmd, exp_cmd); end
    end
  endtask

  task automatic test_overflow();
    bit found;
    int cycles;
    key_q.delete();
    exp_q.delete();
    for (int i = 0; i < 70; i++) begin
      key_q.push_back((i % 26) + 1);
      if (i < 64) exp_q.push_back(6'((i % 26) + 1));
    end
    got_q.delete();
    type_keys();
    n_cmp++; if (cmd !== 8'h20) begin n_err++; $display("FAIL ovf_flag: got %h expected 20", cmd); end
    n_cmp++; if (got_q.size() != 64) begin n_err++; $display("FAIL ovf_echo_count: got %0d expected 64", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_echo[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    ch_input = 8'd66; tick();
    n_cmp++; if (cmd !== 8'h01) begin n_err++; $display("FAIL ovf_enter: got %h expected 01", cmd); end
    got_q.delete();
    wait_done(1'b1, found, cycles);
    n_cmp++; if (!found || cycles < 256) begin n_err++; $display("FAIL ovf_scan_len: found %0d after %0d cycles, expected at least 256", found, cycles); end
    n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL busy_no_echo: got %0d echoes expected 0", got_q.size()); end
    tick();
    n_cmp++; if (cmd !== 8'h08) begin n_err++; $display("FAIL ovf_result: got %h expected 08", cmd); end
  endtask

  task automatic test_backspace();
    bit found;
    int cycles;
    key_q = '{1, 2, 65, 65, 65, 66};
    build_exp();
    got_q.delete();
    erase_cnt = 0;
    type_keys();
    n_cmp++; if (got_q.size() != 2) begin n_err++; $display("FAIL bs_echo_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bs_echo[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (erase_cnt != 2) begin n_err++; $display("FAIL bs_erase_pulses: got %0d expected 2", erase_cnt); end
    wait_done(1'b0, found, cycles);
    n_cmp++; if (!found || cycles > 6) begin n_err++; $display("FAIL bs_done: found %0d after %0d cycles, expected within 6", found, cycles); end
    tick();
    n_cmp++; if (cmd !== 8'h00) begin n_err++; $display("FAIL bs_result: got %h expected 00", cmd); end
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    int cycles;
    key_q = '{1, 2, 66};
    type_keys();
    tick(); tick();
    reset = 1'b1; tick();
    n_cmp++; if (cmd !== 8'h00) begin n_err++; $display("FAIL midscan_cmd: got %h expected 00", cmd); end
    n_cmp++; if (ch_append !== 6'd0) begin n_err++; $display("FAIL midscan_echo: got %0d expected 0", ch_append); end
    reset = 1'b0;
    ch_input = 8'd66; tick();
    n_cmp++; if (cmd !== 8'h01) begin n_err++; $display("FAIL midscan_enter: got %h expected 01", cmd); end
    ch_input = 8'd0;
    wait_done(1'b0, found, cycles);
    n_cmp++; if (!found || cycles > 6) begin n_err++; $display("FAIL midscan_empty: found %0d after %0d cycles, expected within 6", found, cycles); end
    tick();
    n_cmp++; if (cmd !== 8'h00) begin n_err++; $display("FAIL midscan_result: got %h expected 00", cmd); end
  endtask

  initial begin
    test_reset();
    test_definition();
    test_back_to_back();
    test_syntax();
    test_overflow();
    test_backspace();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
